led_serial_shifter: RTL and testbench
=====================================

Name: led_serial_shifter

Overview:
- Serialises a parallel LED/status word onto the board's 74HC164-style LED shift-register chain: data, shift clock, latch enable and clear.
- Sits downstream of the switch/anti-jitter and multiplexer logic. Receives a parallel word plus a periodic start tick taken from the clock divider.
- Drives the LEDCLK, LEDDT, LEDEN and LEDCLR pins at the top level. Any LEDDT polarity inversion is done outside this block.

Parameters:
- DATA_W, 16: number of bits shifted per transfer (2 to 64).
- HALF_CYC, 4: clk cycles per half-period of led_clk (≥1).
- LATCH_CYC, 2: clk cycles led_en stays high after the last bit (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- EN  input  1  transfer enable; start is ignored while EN=0.
- start  input  1  request a transfer; sampled only in IDLE.
- p_data  input  DATA_W  parallel word; captured on the accepting edge.
- led_clk  output  1  serial shift clock to the LED chain.
- led_sout  output  1  serial data, MSB first.
- led_en  output  1  output latch strobe, active high.
- led_clrn  output  1  chain clear, active low.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset values while rst=1, and the cycle it deasserts:
  - state=IDLE; led_clk=0, led_sout=0, led_en=0, busy=0, done=0.
  - led_clrn=0 while rst=1; led_clrn=1 from the first clk edge after rst deasserts.
  - Shift register, bit counter and phase counter are all cleared.
- All outputs are registered; there is no combinational path from input to output.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - On an edge with EN=1 and start=1 (the accepting edge, t0), p_data is loaded into the shift register, bit counter=0, phase counter=0, state→SHIFT, busy→1.
  - start is level-sensitive. If it is held high, a new transfer is accepted on the same edge that returns to IDLE (back-to-back transfers).
- SHIFT:
  - Each bit lasts 2*HALF_CYC cycles.
  - led_sout = shift register MSB for the whole bit period.
  - led_clk=0 for the first HALF_CYC cycles of the bit and 1 for the second HALF_CYC cycles. The rising edge is therefore centred on stable data.
  - At the end of each bit period: shift left by 1 (zero-fill), bit counter +1.
  - After bit DATA_W-1 completes: state→LATCH, led_clk=0.
  - SHIFT occupies cycles t0+1 … t0+DATA_W*2*HALF_CYC.
- LATCH:
  - led_en=1 for exactly LATCH_CYC cycles; led_clk=0; led_sout holds its last value.
  - Then state→IDLE, led_en=0, busy=0. done=1 for exactly the single cycle in which the state re-enters IDLE.
  - done is asserted at cycle t0 + DATA_W*2*HALF_CYC + LATCH_CYC + 1.
- led_en=0 in every cycle outside LATCH.
- start while busy=1 is ignored; no queuing.
- Changes to p_data after t0 do not affect the transfer in progress.
- EN falling mid-transfer does not abort; the transfer completes normally. EN only gates acceptance.
- rst asserted mid-transfer aborts immediately: all outputs take their reset values asynchronously, and led_clrn=0 clears the external chain. No done pulse is produced.
- The phase counter is sized ceil(log2(2*HALF_CYC)) and wraps exactly at 2*HALF_CYC-1. The bit counter is sized ceil(log2(DATA_W+1)). No counter overflow is reachable.

Test Plan:
All scenarios use DATA_W=16, HALF_CYC=2, LATCH_CYC=2 unless stated otherwise.
1. Reset:
   - Stimulus: rst=1 for 5 cycles, then release.
   - Required: all outputs 0 while rst=1, led_clrn=0; led_clrn=1 from the first edge after release; busy=0.
2. Basic transfer:
   - Stimulus: p_data=16'hA5C3, EN=1, one-cycle start.
   - Required: a bench sampling led_sout on each led_clk rising edge reads 1010_0101_1100_0011 (MSB first).
   - Required: exactly 16 led_clk rising edges; led_en high for cycles t0+65 and t0+66 only; done pulse at t0+67; busy high for t0+1 … t0+66.
3. Ignored requests:
   - Stimulus: start pulsed while EN=0.
   - Required: no activity.
   - Stimulus: start re-pulsed and p_data changed to 16'hFFFF at t0+10 during a 16'h0001 transfer.
   - Required: the shifted word is still 16'h0001; no second transfer follows.
4. Back-to-back:
   - Stimulus: start held high continuously, p_data=16'h8001 then 16'h7FFE.
   - Required: the second transfer is accepted on the done edge; its first led_clk rise is 3 cycles after that edge; streams 8001 then 7FFE.
5. Reset mid-transfer:
   - Stimulus: rst asserted at t0+20.
   - Required: led_clk, led_sout and led_en go to 0 and led_clrn to 0 without waiting for a clock edge; no done pulse; a subsequent start performs a clean full transfer.
6. Parameter corner:
   - Stimulus: DATA_W=2, HALF_CYC=1, LATCH_CYC=1, p_data=2'b10.
   - Required: led_clk pattern 0,1,0,1; led_sout 1,1,0,0; led_en at t0+5; done at t0+6.

Source files
------------

// File: rtl/led_serial_shifter.sv
//==============================================================================
// Module   : led_serial_shifter
// Brief    : Serialises a parallel word onto a 74HC164-style LED shift chain.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_serial_shifter #(
    parameter int DATA_W    = 16,
    parameter int HALF_CYC  = 4,
    parameter int LATCH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              start,
    input  logic [DATA_W-1:0] p_data,
    output logic              led_clk,
    output logic              led_sout,
    output logic              led_en,
    output logic              led_clrn,
    output logic              busy,
    output logic              done
);

    localparam int PH_W = $clog2(2 * HALF_CYC);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int LC_W = $clog2(LATCH_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic [PH_W-1:0] c_PH_HALF  = PH_W'(HALF_CYC - 1);
    localparam logic [PH_W-1:0] c_PH_LAST  = PH_W'(2 * HALF_CYC - 1);
    localparam logic [BC_W-1:0] c_BIT_LAST = BC_W'(DATA_W - 1);
    localparam logic [LC_W-1:0] c_LAT_LAST = LC_W'(LATCH_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_sreg;
    logic [PH_W-1:0]   r_phase;
    logic [BC_W-1:0]   r_bit;
    logic [LC_W-1:0]   r_lcnt;

    logic w_accept, w_bit_end, w_last_bit, w_lat_end, w_load;
    logic w_clk_nxt, w_sout_nxt, w_en_nxt, w_busy_nxt, w_done_nxt;

    assign w_accept   = EN & start;
    assign w_bit_end  = (r_phase == c_PH_LAST);
    assign w_last_bit = w_bit_end && (r_bit == c_BIT_LAST);
    assign w_lat_end  = (r_lcnt == c_LAT_LAST);
    // A held start re-arms on the very edge that leaves LATCH.
    assign w_load     = w_accept && ((r_state == S_IDLE) ||
                                     ((r_state == S_LATCH) && w_lat_end));

    // State register, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sreg   <= '0;
            r_phase  <= '0;
            r_bit    <= '0;
            r_lcnt   <= '0;
            led_clk  <= 1'b0;
            led_sout <= 1'b0;
            led_en   <= 1'b0;
            led_clrn <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            led_clk  <= w_clk_nxt;
            led_sout <= w_sout_nxt;
            led_en   <= w_en_nxt;
            led_clrn <= 1'b1;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
            if (w_load) begin
                r_sreg  <= p_data;
                r_phase <= '0;
                r_bit   <= '0;
                r_lcnt  <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_bit_end) begin
                    r_phase <= '0;
                    r_sreg  <= {r_sreg[DATA_W-2:0], 1'b0};
                    r_bit   <= r_bit + 1'b1;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end else if (r_state == S_LATCH) begin
                r_lcnt <= w_lat_end ? '0 : r_lcnt + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_nxt = S_LATCH;
            S_LATCH: if (w_lat_end) w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_clk_nxt  = 1'b0;
        w_sout_nxt = led_sout;
        w_en_nxt   = 1'b0;
        w_busy_nxt = busy;
        w_done_nxt = (r_state == S_LATCH) && w_lat_end;
        if (w_load) begin
            w_sout_nxt = p_data[DATA_W-1];
            w_busy_nxt = 1'b1;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (w_last_bit) begin
                        w_en_nxt = 1'b1;
                    end else if (w_bit_end) begin
                        w_sout_nxt = r_sreg[DATA_W-2];
                    end else begin
                        // Clock goes high for the second half of the bit period
                        w_clk_nxt = (r_phase >= c_PH_HALF);
                    end
                end
                S_LATCH: begin
                    w_en_nxt = !w_lat_end;
                    if (w_lat_end) w_busy_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_serial_shifter.sv
//==============================================================================
// Module   : tb_led_serial_shifter
// Brief    : Directed self-checking bench for led_serial_shifter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_serial_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EN = 1'b0;
    logic        start = 1'b0;
    logic [15:0] p_data = '0;
    logic        led_clk, led_sout, led_en, led_clrn, busy, done;

    logic        cr_en = 1'b0;
    logic        cr_start = 1'b0;
    logic [1:0]  cr_data = '0;
    logic        cr_led_clk, cr_led_sout, cr_led_en, cr_led_clrn, cr_busy, cr_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] cap_word;
    int n_rise, en_first, en_last, en_cnt, done_cnt, busy_first, busy_last, busy_cnt;
    int rise_cyc [0:63];
    int done_cyc [0:3];

    always #5 clk = ~clk;

    led_serial_shifter #(.DATA_W(16), .HALF_CYC(2), .LATCH_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .EN(EN), .start(start), .p_data(p_data),
        .led_clk(led_clk), .led_sout(led_sout), .led_en(led_en),
        .led_clrn(led_clrn), .busy(busy), .done(done)
    );

    led_serial_shifter #(.DATA_W(2), .HALF_CYC(1), .LATCH_CYC(1)) u_dut_corner (
        .clk(clk), .rst(rst), .EN(cr_en), .start(cr_start), .p_data(cr_data),
        .led_clk(cr_led_clk), .led_sout(cr_led_sout), .led_en(cr_led_en),
        .led_clrn(cr_led_clrn), .busy(cr_busy), .done(cr_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a start on edge t0, then record activity for cycles t0+1 .. t0+ncyc.
    task automatic capture(input logic [15:0] d, input logic en_v, input int ncyc,
                           input int inj_cyc, input logic [15:0] inj_d, input logic hold);
        logic prev_clk;
        prev_clk = 1'b0;
        cap_word = '0; n_rise = 0; en_first = -1; en_last = -1; en_cnt = 0;
        done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        for (int i = 0; i < 64; i++) rise_cyc[i] = -1;
        for (int i = 0; i < 4; i++) done_cyc[i] = -1;
        p_data = d;
        EN     = en_v;
        start  = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (led_clk && !prev_clk) begin
                if (n_rise < 64) rise_cyc[n_rise] = k;
                n_rise++;
                cap_word = {cap_word[62:0], led_sout};
            end
            prev_clk = led_clk;
            if (led_en) begin
                if (en_cnt == 0) en_first = k;
                en_last = k;
                en_cnt++;
            end
            if (done) begin
                if (done_cnt < 4) done_cyc[done_cnt] = k;
                done_cnt++;
            end
            if (busy) begin
                if (busy_cnt == 0) busy_first = k;
                busy_last = k;
                busy_cnt++;
            end
            if (k == inj_cyc) begin
                p_data = inj_d;
                start  = 1'b1;
            end else if (k == inj_cyc + 1 && !hold) begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        EN    = 1'b1;
    endtask

    logic [5:0] e_clk, e_sout, e_en, e_done;

    initial begin
        // Reset
        repeat (5) tick();
        check("rst_clk", led_clk, 0);
        check("rst_sout", led_sout, 0);
        check("rst_en", led_en, 0);
        check("rst_clrn", led_clrn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        check("rel_clrn_before_edge", led_clrn, 0);
        tick();
        check("rel_clrn_after_edge", led_clrn, 1);
        check("rel_busy", busy, 0);

        // Basic transfer
        capture(16'hA5C3, 1'b1, 70, -1, 16'h0, 1'b0);
        check("basic_word", cap_word[15:0], 16'hA5C3);
        check("basic_nrise", n_rise, 16);
        check("basic_en_first", en_first, 65);
        check("basic_en_last", en_last, 66);
        check("basic_en_cnt", en_cnt, 2);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_done_cyc", done_cyc[0], 67);
        check("basic_busy_first", busy_first, 1);
        check("basic_busy_last", busy_last, 66);
        check("basic_busy_cnt", busy_cnt, 66);
        check("basic_first_rise", rise_cyc[0], 3);

        // Start while EN=0
        capture(16'hFFFF, 1'b0, 20, -1, 16'h0, 1'b0);
        check("en0_nrise", n_rise, 0);
        check("en0_busy", busy_cnt, 0);
        check("en0_done", done_cnt, 0);

        // Re-pulse with new data mid-transfer
        capture(16'h0001, 1'b1, 100, 10, 16'hFFFF, 1'b0);
        check("ign_word", cap_word[15:0], 16'h0001);
        check("ign_nrise", n_rise, 16);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_busy_last", busy_last, 66);

        // Back-to-back with start held high
        capture(16'h8001, 1'b1, 134, 1, 16'h7FFE, 1'b1);
        check("b2b_word", cap_word[31:0], 32'h8001_7FFE);
        check("b2b_nrise", n_rise, 32);
        check("b2b_second_rise", rise_cyc[16], 69);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_done0", done_cyc[0], 67);
        check("b2b_done1", done_cyc[1], 133);
        check("b2b_busy_cnt", busy_cnt, 134);
        repeat (80) tick();
        check("b2b_idle_busy", busy, 0);

        // Reset mid-transfer
        capture(16'hFFFF, 1'b1, 19, -1, 16'h0, 1'b0);
        check("mid_busy_before", busy, 1);
        check("mid_sout_before", led_sout, 1);
        rst = 1'b1;
        #1;
        check("mid_clk", led_clk, 0);
        check("mid_sout", led_sout, 0);
        check("mid_en", led_en, 0);
        check("mid_clrn", led_clrn, 0);
        check("mid_busy", busy, 0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) done_cnt++;
            tick();
        end
        check("mid_no_done", done_cnt, 0);
        capture(16'hA5C3, 1'b1, 70, -1, 16'h0, 1'b0);
        check("mid_after_word", cap_word[15:0], 16'hA5C3);
        check("mid_after_nrise", n_rise, 16);
        check("mid_after_done", done_cyc[0], 67);

        // Parameter corner: DATA_W=2, HALF_CYC=1, LATCH_CYC=1
        e_clk  = 6'b001010;
        e_sout = 6'b000011;
        e_en   = 6'b010000;
        e_done = 6'b100000;
        cr_data  = 2'b10;
        cr_en    = 1'b1;
        cr_start = 1'b1;
        tick();
        cr_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("corner_clk_c%0d", k), cr_led_clk, e_clk[k-1]);
            check($sformatf("corner_sout_c%0d", k), cr_led_sout, e_sout[k-1]);
            check($sformatf("corner_en_c%0d", k), cr_led_en, e_en[k-1]);
            check($sformatf("corner_done_c%0d", k), cr_done, e_done[k-1]);
            tick();
        end
        check("corner_busy_end", cr_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
